// File: rtl/mem_delayed.sv
// mem_delayed: word-organised behavioural memory with a fixed access latency.
// Optional MEM_DELAYED_OOB_CHECK_EN discards/zeroes out-of-range accesses.
module mem_delayed #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DELAY      = 5,
    parameter int MEM_WORDS  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  ack
);

    localparam int WW    = ADDR_WIDTH - 2;
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CW    = 5;

    localparam logic [WW-1:0] WORDS_W = WW'(MEM_WORDS);
    localparam logic [CW-1:0] DLY     = CW'(DELAY);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  op_wr_q, op_wr_d;
    logic [WW-1:0]         word_q, word_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done;

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS] = '{default: '0};

    logic [WW-1:0]    word_mod;
    logic [IDX_W-1:0] idx;
    logic             oob;
    logic             unused_bits;

    assign word_mod    = word_q % WORDS_W;
    assign idx         = word_mod[IDX_W-1:0];
    assign unused_bits = ^{word_mod, addr[1:0]};

`ifdef MEM_DELAYED_OOB_CHECK_EN
    assign oob = (word_q >= WORDS_W);
`else
    assign oob = 1'b0;
`endif

    // Next-state: accept a request when idle, count down the latency when busy
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        op_wr_d = op_wr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (rd_req | wr_req) begin
                    state_d = S_BUSY;
                    cnt_d   = DLY;
                    busy_d  = 1'b1;
                    op_wr_d = wr_req;
                    word_d  = addr[ADDR_WIDTH-1:2];
                    wdata_d = wr_data;
                end
            end
            S_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    if (!op_wr_q) begin
                        rdata_d = oob ? '0 : mem_q[idx];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            op_wr_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            op_wr_q <= op_wr_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
        end
    end

    // Storage commit on write completion; reset aborts a pending write
    always_ff @(posedge clk) begin
        if (!rst && done && op_wr_q && !oob) begin
            mem_q[idx] <= wdata_q;
        end
    end

`ifdef MEM_DELAYED_OOB_CHECK_EN
    // Flag out-of-range accesses as they complete
    always_ff @(posedge clk) begin
        if (!rst && done && oob) begin
            $warning("mem_delayed: out-of-range access at addr %h",
                     {word_q, 2'b00});
        end
    end
`endif

    assign rd_data = rdata_q;
    assign busy    = busy_q;
    assign ack     = ack_q;

endmodule

// File: tb/tb_mem_delayed.sv
// tb_mem_delayed: scoreboard bench for mem_delayed.
// Expected read data is queued at request time and popped at ack.
module tb_mem_delayed;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DLY   = 5;
    localparam int WORDS = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req;
    logic          wr_req;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          ack;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [int];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_rd;

    mem_delayed #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DELAY     (DLY),
        .MEM_WORDS (WORDS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rd_req (rd_req),
        .wr_req (wr_req),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .busy   (busy),
        .ack    (ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [AW-1:0] a);
        return int'((a >> 2) % WORDS);
    endfunction

    function automatic logic [DW-1:0] mget(input logic [AW-1:0] a);
        if (model.exists(widx(a))) return model[widx(a)];
        return '0;
    endfunction

    // Called #1 after the accept edge; returns #1 after the ack edge
    task automatic wait_done(input bit is_rd);
        int n = 0;
        logic [DW-1:0] e;
        while (busy === 1'b1 && n < 40) begin
            if (ack !== 1'b0) check("ack_while_busy", {31'b0, ack}, '0);
            n++;
            @(posedge clk); #1;
        end
        check("busy_cycles", n, DLY);
        check("ack_pulse", {31'b0, ack}, 32'd1);
        check("busy_in_ack", {31'b0, busy}, '0);
        if (is_rd) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", rd_data, e);
                last_rd = e;
            end
        end else begin
            check("rd_hold", rd_data, last_rd);
        end
    endtask

    task automatic access(input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit xfill);
        rd_req  = !wr;
        wr_req  = wr;
        addr    = a;
        wr_data = d;
        if (wr) model[widx(a)] = d;
        else exp_q.push_back(mget(a));
        @(posedge clk); #1;
        if (xfill) begin
            rd_req  = 1'bx;
            wr_req  = 1'bx;
            addr    = 'x;
            wr_data = 'x;
        end else begin
            rd_req = 1'b0;
            wr_req = 1'b0;
        end
        wait_done(!wr);
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        addr    = '0;
        wr_data = '0;
    endtask

    initial begin
        rst     = 1'b1;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        addr    = '0;
        wr_data = '0;
        last_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, '0);
        check("rst_ack", {31'b0, ack}, '0);
        check("rst_rd_data", rd_data, '0);
        @(posedge clk); #1;

        access(1, 32'h8, 32'hab, 0);
        access(1, 32'h10, 32'hcd, 0);
        for (int i = 0; i < 2; i++) begin
            access(0, 32'h10, '0, 0);
            access(0, 32'h8, '0, 0);
        end

        access(1, 32'h14, 32'h11, 0);
        access(1, 32'h18, 32'h22, 0);
        access(0, 32'h14, '0, 0);
        access(0, 32'h18, '0, 0);
        access(0, 32'h10, '0, 0);
        access(0, 32'h8, '0, 0);

        access(1, 32'h8, 32'hab, 0);
        access(1, 32'hb, 32'hcd, 0);
        access(0, 32'h8, '0, 0);
        access(1, 32'h8, 32'hab, 0);
        access(1, 32'hc, 32'hcd, 0);
        access(0, 32'h8, '0, 0);
        access(0, 32'hc, '0, 0);

        // Word index beyond MEM_WORDS wraps onto low storage
        access(1, 32'h4004, 32'h77, 0);
        access(0, 32'h4, '0, 0);

        // Inputs go X after acceptance
        access(1, 32'h20, 32'h5a5a, 1);
        access(0, 32'h20, '0, 0);

        // rd_req held through busy: re-accepted only at the ack-cycle edge
        rd_req = 1'b1;
        addr   = 32'h18;
        exp_q.push_back(mget(32'h18));
        exp_q.push_back(mget(32'h18));
        @(posedge clk); #1;
        wait_done(1);
        @(posedge clk); #1;
        check("retrigger_busy", {31'b0, busy}, 32'd1);
        check("retrigger_ack", {31'b0, ack}, '0);
        rd_req = 1'b0;
        wait_done(1);
        @(posedge clk); #1;
        check("idle_busy", {31'b0, busy}, '0);

        // Reset during a write drops it
        wr_req  = 1'b1;
        addr    = 32'h8;
        wr_data = 32'h99;
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = '0;
        check("abort_busy", {31'b0, busy}, '0);
        check("abort_ack", {31'b0, ack}, '0);
        check("abort_rd_data", rd_data, '0);
        access(0, 32'h8, '0, 0);

        check("scoreboard_drained", exp_q.size(), '0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
